// File: rtl/display_scanner.sv
// display_scanner: multiplexed common-anode 7-segment driver for up to eight
// digits with frame-synchronous loading, per-digit enables, decimal points,
// leading-zero suppression and an inter-digit blanking interval.
module display_scanner #(
    parameter int NDIG    = 8,
    parameter int CLK_DIV = 625,
    parameter int BLANK   = 16
) (
    input  logic                clk5,
    input  logic                reset,
    input  logic [4*NDIG-1:0]   dispVal,
    input  logic [NDIG-1:0]     dpIn,
    input  logic [NDIG-1:0]     enDigit,
    input  logic                lzSuppress,
    input  logic                load,
    output logic                loaded,
    output logic                frame,
    output logic [NDIG-1:0]     digit,
    output logic [7:0]          segment
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int SW = $clog2(NDIG);

    logic [PW-1:0]     prescaler;
    logic [SW-1:0]     slot;
    logic              tick;
    logic              boundary;

    logic [4*NDIG-1:0] hold_val;
    logic [NDIG-1:0]   hold_dp;
    logic              pending;
    logic [4*NDIG-1:0] act_val;
    logic [NDIG-1:0]   act_dp;
    logic              update_d;
    logic              boundary_d;

    logic [NDIG-1:0]   zero_from;
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              suppressed;
    logic              lit_phase;
    logic [NDIG-1:0]   digit_next;
    logic [7:0]        segment_next;

    // Segment pattern a..g for a hex nibble, 0 = lit
    function automatic logic [6:0] font(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'b0000001;
            4'h1: pat = 7'b1001111;
            4'h2: pat = 7'b0010010;
            4'h3: pat = 7'b0000110;
            4'h4: pat = 7'b1001100;
            4'h5: pat = 7'b0100100;
            4'h6: pat = 7'b0100000;
            4'h7: pat = 7'b0001111;
            4'h8: pat = 7'b0000000;
            4'h9: pat = 7'b0000100;
            4'hA: pat = 7'b0001000;
            4'hB: pat = 7'b1100000;
            4'hC: pat = 7'b0110001;
            4'hD: pat = 7'b1000010;
            4'hE: pat = 7'b0110000;
            default: pat = 7'b0111000;
        endcase
        return pat;
    endfunction

    assign tick     = (prescaler == PW'(CLK_DIV - 1));
    assign boundary = tick && (slot == SW'(NDIG - 1));

    // Prescaler and slot index: one slot per CLK_DIV cycles, wrapping per frame
    always_ff @(posedge clk5 or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            slot      <= '0;
        end else if (tick) begin
            prescaler <= '0;
            slot      <= boundary ? '0 : slot + SW'(1);
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Holding/active value registers; active only changes on a frame boundary
    always_ff @(posedge clk5 or negedge reset) begin
        if (!reset) begin
            hold_val   <= '0;
            hold_dp    <= '0;
            pending    <= 1'b0;
            act_val    <= '0;
            act_dp     <= '0;
            update_d   <= 1'b0;
            boundary_d <= 1'b0;
        end else begin
            boundary_d <= boundary;
            update_d   <= boundary && (load || pending);
            if (load) begin
                hold_val <= dispVal;
                hold_dp  <= dpIn;
            end
            if (boundary) begin
                if (load) begin
                    act_val <= dispVal;
                    act_dp  <= dpIn;
                end else if (pending) begin
                    act_val <= hold_val;
                    act_dp  <= hold_dp;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // zero_from[i] is set when every nibble from i upward is zero
    always_comb begin
        logic acc;
        acc       = 1'b1;
        zero_from = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            acc          = acc && (act_val[4*i +: 4] == 4'h0);
            zero_from[i] = acc;
        end
    end

    // Next anode/cathode pattern for the slot currently being scanned
    always_comb begin
        digit_next   = '1;
        segment_next = 8'hFF;
        cur_nib      = act_val[{slot, 2'b00} +: 4];
        cur_dp       = act_dp[slot];
        suppressed   = lzSuppress && (slot != '0) && zero_from[slot];
        lit_phase    = (int'(prescaler) >= BLANK);
        if (lit_phase && enDigit[slot] && !(suppressed && !cur_dp)) begin
            digit_next[slot] = 1'b0;
            segment_next     = suppressed ? {7'h7F, ~cur_dp} : {font(cur_nib), ~cur_dp};
        end
    end

    // Registered outputs, one clock behind the scan state
    always_ff @(posedge clk5 or negedge reset) begin
        if (!reset) begin
            digit   <= '1;
            segment <= 8'hFF;
            frame   <= 1'b0;
            loaded  <= 1'b0;
        end else begin
            digit   <= digit_next;
            segment <= segment_next;
            frame   <= boundary_d;
            loaded  <= update_d;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: directed checks of scanning, loading, suppression,
// enables, blanking and reset for display_scanner (NDIG=8, CLK_DIV=20, BLANK=4).
module tb_display_scanner;

    localparam int NDIG    = 8;
    localparam int CLK_DIV = 20;
    localparam int BLANK   = 4;
    localparam int FRAME   = NDIG * CLK_DIV;

    logic        clk5 = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] dispVal = '0;
    logic [7:0]  dpIn = '0;
    logic [7:0]  enDigit = 8'hFF;
    logic        lzSuppress = 1'b0;
    logic        load = 1'b0;
    logic        loaded;
    logic        frame;
    logic [7:0]  digit;
    logic [7:0]  segment;

    int checks = 0;
    int errors = 0;

    // Observations gathered over one frame
    logic [7:0] seg_cap [8];
    logic [7:0] dig_cap [8];
    int         lowcnt [8];
    int         blank_bad;
    int         onehot_bad;
    int         extra_frame;
    int         extra_loaded;
    logic       frame0;
    logic       loaded0;

    // Load schedule used during a capture (-1 = none)
    int          ld_k1 = -1;
    int          ld_k2 = -1;
    logic [31:0] ld_v1, ld_v2;
    logic [7:0]  ld_dp1, ld_dp2;

    display_scanner #(.NDIG(NDIG), .CLK_DIV(CLK_DIV), .BLANK(BLANK)) dut (
        .clk5       (clk5),
        .reset      (reset),
        .dispVal    (dispVal),
        .dpIn       (dpIn),
        .enDigit    (enDigit),
        .lzSuppress (lzSuppress),
        .load       (load),
        .loaded     (loaded),
        .frame      (frame),
        .digit      (digit),
        .segment    (segment)
    );

    always #5 clk5 = ~clk5;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk5);
        #1;
    endtask

    // Waits for a frame pulse; a timeout is a failure
    task automatic wait_frame(output int waited);
        waited = 0;
        while (frame !== 1'b1 && waited < 3 * FRAME) begin
            step();
            waited++;
        end
        checks++;
        if (frame !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait_frame: frame=%b after %0d cycles, required 1", frame, waited);
        end
    endtask

    // Samples outputs for stop_k cycles starting at a frame pulse, driving scheduled loads
    task automatic capture(input int stop_k);
        int s, p;
        logic [7:0] onehot;
        for (int i = 0; i < 8; i++) begin
            seg_cap[i] = 8'hXX;
            dig_cap[i] = 8'hXX;
            lowcnt[i]  = 0;
        end
        blank_bad = 0; onehot_bad = 0; extra_frame = 0; extra_loaded = 0;
        for (int k = 0; k < stop_k; k++) begin
            s = k / CLK_DIV;
            p = k % CLK_DIV;
            if (k == 0) begin
                frame0  = frame;
                loaded0 = loaded;
            end else begin
                if (frame !== 1'b0)  extra_frame++;
                if (loaded !== 1'b0) extra_loaded++;
            end
            if (p < BLANK) begin
                if (digit !== 8'hFF || segment !== 8'hFF) blank_bad++;
            end else begin
                onehot = ~(8'd1 << s);
                if (digit !== 8'hFF) begin
                    if (digit !== onehot) onehot_bad++;
                    else lowcnt[s]++;
                end
                if (p == 10) begin
                    seg_cap[s] = segment;
                    dig_cap[s] = digit;
                end
            end
            if (k == ld_k1) begin
                load = 1'b1; dispVal = ld_v1; dpIn = ld_dp1;
            end else if (k == ld_k2) begin
                load = 1'b1; dispVal = ld_v2; dpIn = ld_dp2;
            end else begin
                load = 1'b0;
            end
            step();
        end
        load  = 1'b0;
        ld_k1 = -1;
        ld_k2 = -1;
    endtask

    task automatic test_reset();
        int waited;
        repeat (3) step();
        checks++; if (digit !== 8'hFF)   begin errors++; $display("[TB] FAIL reset_digit: got %h, required ff", digit); end
        checks++; if (segment !== 8'hFF) begin errors++; $display("[TB] FAIL reset_segment: got %h, required ff", segment); end
        checks++; if (loaded !== 1'b0)   begin errors++; $display("[TB] FAIL reset_loaded: got %b, required 0", loaded); end
        checks++; if (frame !== 1'b0)    begin errors++; $display("[TB] FAIL reset_frame: got %b, required 0", frame); end
        reset = 1'b1;
        wait_frame(waited);
        checks++;
        if (waited < FRAME || waited > FRAME + 1) begin
            errors++;
            $display("[TB] FAIL first_frame_delay: got %0d cycles, required %0d..%0d", waited, FRAME, FRAME + 1);
        end
        capture(FRAME);
        checks++; if (loaded0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_loaded: got %b, required 0", loaded0); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seg_cap[i] !== 8'h03) begin errors++; $display("[TB] FAIL zero_seg[%0d]: got %h, required 03", i, seg_cap[i]); end
            checks++;
            if (lowcnt[i] !== CLK_DIV - BLANK) begin errors++; $display("[TB] FAIL lit_time[%0d]: got %0d, required %0d", i, lowcnt[i], CLK_DIV - BLANK); end
        end
        checks++; if (blank_bad !== 0)   begin errors++; $display("[TB] FAIL blanking: got %0d bad cycles, required 0", blank_bad); end
        checks++; if (onehot_bad !== 0)  begin errors++; $display("[TB] FAIL onehot: got %0d bad cycles, required 0", onehot_bad); end
        checks++; if (extra_frame !== 0) begin errors++; $display("[TB] FAIL extra_frame: got %0d, required 0", extra_frame); end
        checks++; if (frame !== 1'b1)    begin errors++; $display("[TB] FAIL frame_period: frame=%b at cycle %0d, required 1", frame, FRAME); end
    endtask

    task automatic test_load_midframe();
        logic [7:0] exp [4];
        exp[0] = 8'h00; exp[1] = 8'h71; exp[2] = 8'h9F; exp[3] = 8'h11;
        ld_k1 = 50; ld_v1 = 32'h0000_A1F8; ld_dp1 = 8'h01;
        capture(FRAME);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seg_cap[i] !== 8'h03) begin errors++; $display("[TB] FAIL midframe_unchanged[%0d]: got %h, required 03", i, seg_cap[i]); end
        end
        capture(FRAME);
        checks++; if (loaded0 !== 1'b1) begin errors++; $display("[TB] FAIL load_loaded: got %b, required 1", loaded0); end
        checks++; if (frame0 !== 1'b1)  begin errors++; $display("[TB] FAIL load_frame: got %b, required 1", frame0); end
        checks++; if (extra_loaded !== 0) begin errors++; $display("[TB] FAIL loaded_width: got %0d extra, required 0", extra_loaded); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seg_cap[i] !== exp[i]) begin errors++; $display("[TB] FAIL load_seg[%0d]: got %h, required %h", i, seg_cap[i], exp[i]); end
        end
        for (int i = 4; i < 8; i++) begin
            checks++;
            if (seg_cap[i] !== 8'h03) begin errors++; $display("[TB] FAIL load_upper[%0d]: got %h, required 03", i, seg_cap[i]); end
        end
    endtask

    task automatic test_lz_suppress();
        lzSuppress = 1'b1;
        ld_k1 = 20; ld_v1 = 32'h0000_A1F8; ld_dp1 = 8'h21;
        capture(FRAME);
        checks++; if (seg_cap[1] !== 8'h71) begin errors++; $display("[TB] FAIL lz_digit1: got %h, required 71", seg_cap[1]); end
        checks++; if (seg_cap[3] !== 8'h11) begin errors++; $display("[TB] FAIL lz_digit3: got %h, required 11", seg_cap[3]); end
        for (int i = 4; i < 8; i++) begin
            checks++;
            if (lowcnt[i] !== 0 || dig_cap[i] !== 8'hFF) begin
                errors++; $display("[TB] FAIL lz_dark[%0d]: lowcnt %0d anode %h, required 0 ff", i, lowcnt[i], dig_cap[i]);
            end
        end
        capture(FRAME);
        checks++; if (seg_cap[5] !== 8'hFE) begin errors++; $display("[TB] FAIL lz_dp_seg: got %h, required fe", seg_cap[5]); end
        checks++; if (dig_cap[5] !== 8'hDF) begin errors++; $display("[TB] FAIL lz_dp_anode: got %h, required df", dig_cap[5]); end
        checks++; if (lowcnt[4] !== 0)      begin errors++; $display("[TB] FAIL lz_dark4: got %0d lit cycles, required 0", lowcnt[4]); end
        checks++; if (seg_cap[0] !== 8'h00) begin errors++; $display("[TB] FAIL lz_digit0: got %h, required 00", seg_cap[0]); end
        lzSuppress = 1'b0;
    endtask

    task automatic test_back_to_back();
        ld_k1 = 30; ld_v1 = 32'h1111_1111; ld_dp1 = 8'h00;
        ld_k2 = 90; ld_v2 = 32'h2222_2222; ld_dp2 = 8'h00;
        capture(FRAME);
        checks++; if (seg_cap[0] !== 8'h00) begin errors++; $display("[TB] FAIL b2b_unchanged: got %h, required 00", seg_cap[0]); end
        ld_k1 = FRAME - 2; ld_v1 = 32'h3333_3333; ld_dp1 = 8'h00;
        capture(FRAME);
        checks++; if (loaded0 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_loaded: got %b, required 1", loaded0); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seg_cap[i] !== 8'h25) begin errors++; $display("[TB] FAIL last_wins[%0d]: got %h, required 25", i, seg_cap[i]); end
        end
        capture(FRAME);
        checks++; if (loaded0 !== 1'b1) begin errors++; $display("[TB] FAIL boundary_loaded: got %b, required 1", loaded0); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seg_cap[i] !== 8'h0D) begin errors++; $display("[TB] FAIL boundary_load[%0d]: got %h, required 0d", i, seg_cap[i]); end
        end
    endtask

    task automatic test_enable();
        enDigit = 8'hFE;
        capture(FRAME);
        checks++; if (lowcnt[0] !== 0)      begin errors++; $display("[TB] FAIL en_dark0: got %0d lit cycles, required 0", lowcnt[0]); end
        checks++; if (seg_cap[0] !== 8'hFF) begin errors++; $display("[TB] FAIL en_seg0: got %h, required ff", seg_cap[0]); end
        checks++; if (lowcnt[1] !== CLK_DIV - BLANK) begin errors++; $display("[TB] FAIL en_lit1: got %0d, required %0d", lowcnt[1], CLK_DIV - BLANK); end
        checks++; if (blank_bad !== 0)  begin errors++; $display("[TB] FAIL en_blanking: got %0d, required 0", blank_bad); end
        checks++; if (onehot_bad !== 0) begin errors++; $display("[TB] FAIL en_onehot: got %0d, required 0", onehot_bad); end
        checks++; if (loaded0 !== 1'b0) begin errors++; $display("[TB] FAIL en_no_loaded: got %b, required 0", loaded0); end
        enDigit = 8'hFF;
    endtask

    task automatic test_reset_midframe();
        int waited;
        ld_k1 = 40; ld_v1 = 32'h4444_4444; ld_dp1 = 8'hFF;
        capture(5 * CLK_DIV + 5);
        checks++; if (digit !== 8'hDF) begin errors++; $display("[TB] FAIL pre_reset_anode: got %h, required df", digit); end
        reset = 1'b0;
        #1;
        checks++; if (digit !== 8'hFF)   begin errors++; $display("[TB] FAIL async_digit: got %h, required ff", digit); end
        checks++; if (segment !== 8'hFF) begin errors++; $display("[TB] FAIL async_segment: got %h, required ff", segment); end
        step();
        reset = 1'b1;
        wait_frame(waited);
        checks++;
        if (waited < FRAME || waited > FRAME + 1) begin
            errors++; $display("[TB] FAIL restart_delay: got %0d cycles, required %0d..%0d", waited, FRAME, FRAME + 1);
        end
        capture(FRAME);
        checks++; if (loaded0 !== 1'b0) begin errors++; $display("[TB] FAIL restart_loaded: got %b, required 0", loaded0); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seg_cap[i] !== 8'h03) begin errors++; $display("[TB] FAIL restart_seg[%0d]: got %h, required 03", i, seg_cap[i]); end
        end
    endtask

    task automatic test_zero_value();
        lzSuppress = 1'b1;
        capture(FRAME);
        checks++; if (seg_cap[0] !== 8'h03) begin errors++; $display("[TB] FAIL zero_digit0: got %h, required 03", seg_cap[0]); end
        for (int i = 1; i < 8; i++) begin
            checks++;
            if (lowcnt[i] !== 0) begin errors++; $display("[TB] FAIL zero_dark[%0d]: got %0d lit cycles, required 0", i, lowcnt[i]); end
        end
        lzSuppress = 1'b0;
    endtask

    initial begin
        $display("[TB] display_scanner directed tests");
        test_reset();
        test_load_midframe();
        test_lz_suppress();
        test_back_to_back();
        test_enable();
        test_reset_midframe();
        test_zero_value();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
